twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/r22sdf_pkg.sv | 56 +++++
 rtl/twiddle_rom.sv | 52 +++++
 rtl/twiddle_gen.sv | 121 ++++++++++++
 tb/tb_twiddle_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/r22sdf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : r22sdf_pkg
// Description : Shared defaults, octant codes and twiddle fold helper for R2^2SDF.
// Revision    : 1.0
// ============================================================================
package r22sdf_pkg;

  localparam int  c_def_log_n = 6;
  localparam int  c_def_width = 16;
  localparam int  c_max_log_n = 12;
  localparam int  c_j_w       = c_max_log_n - 2;
  localparam real c_pi        = 3.14159265358979323846;

  localparam logic [2:0] c_oct_0 = 3'd0;
  localparam logic [2:0] c_oct_1 = 3'd1;
  localparam logic [2:0] c_oct_2 = 3'd2;
  localparam logic [2:0] c_oct_3 = 3'd3;
  localparam logic [2:0] c_oct_4 = 3'd4;
  localparam logic [2:0] c_oct_5 = 3'd5;
  localparam logic [2:0] c_oct_6 = 3'd6;
  localparam logic [2:0] c_oct_7 = 3'd7;

  typedef struct packed {
    logic [c_j_w-1:0] j;
    logic             swap;
    logic             neg_c;
    logic             neg_s;
  } fold_t;

  // Maps k to the first-octant index plus how cos/sin of the angle are rebuilt.
  function automatic fold_t fold(input logic [c_max_log_n-1:0] k, input int log_n);
    logic [c_max_log_n-1:0] eighth;
    logic [c_max_log_n-1:0] r;
    logic [2:0]             oct;
    fold_t                  f;
    oct    = 3'(k >> (log_n - 3));
    eighth = c_max_log_n'(1) << (log_n - 3);
    r      = k & (eighth - c_max_log_n'(1));
    f      = '0;
    f.j    = c_j_w'(oct[0] ? (eighth - r) : r);
    case (oct)
      c_oct_0: begin f.swap = 1'b0; f.neg_c = 1'b0; f.neg_s = 1'b0; end
      c_oct_1: begin f.swap = 1'b1; f.neg_c = 1'b0; f.neg_s = 1'b0; end
      c_oct_2: begin f.swap = 1'b1; f.neg_c = 1'b1; f.neg_s = 1'b0; end
      c_oct_3: begin f.swap = 1'b0; f.neg_c = 1'b1; f.neg_s = 1'b0; end
      c_oct_4: begin f.swap = 1'b0; f.neg_c = 1'b1; f.neg_s = 1'b1; end
      c_oct_5: begin f.swap = 1'b1; f.neg_c = 1'b1; f.neg_s = 1'b1; end
      c_oct_6: begin f.swap = 1'b1; f.neg_c = 1'b0; f.neg_s = 1'b1; end
      default: begin f.swap = 1'b0; f.neg_c = 1'b0; f.neg_s = 1'b1; end
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_rom.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_rom
// Description : First-octant cos/sin magnitude table, N/8+1 entries, sync read.
// Revision    : 1.0
// ============================================================================
module twiddle_rom
  import r22sdf_pkg::*;
#(
  parameter int LOG_N = c_def_log_n,
  parameter int WIDTH = c_def_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [LOG_N-3:0] addr,
  output logic [WIDTH-1:0] cos_mag,
  output logic [WIDTH-1:0] sin_mag
);

  localparam int  c_depth = (1 << (LOG_N - 3)) + 1;
  localparam real c_scale = $itor(1 << (WIDTH - 1));

  logic [WIDTH-1:0] w_cos_tab [c_depth];
  logic [WIDTH-1:0] w_sin_tab [c_depth];
  logic [WIDTH-1:0] r_cos;
  logic [WIDTH-1:0] r_sin;

  // Unsigned magnitudes; cos(0) keeps the full 2^(WIDTH-1) so negation stays exact.
  for (genvar j = 0; j < c_depth; j++) begin : g_tab
    localparam real c_ang = 2.0 * c_pi * j / $itor(1 << LOG_N);
    localparam logic [WIDTH-1:0] c_cos = WIDTH'($rtoi($cos(c_ang) * c_scale + 0.5));
    localparam logic [WIDTH-1:0] c_sin = WIDTH'($rtoi($sin(c_ang) * c_scale + 0.5));
    assign w_cos_tab[j] = c_cos;
    assign w_sin_tab[j] = c_sin;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cos <= '0;
      r_sin <= '0;
    end else if (en) begin
      r_cos <= w_cos_tab[addr];
      r_sin <= w_sin_tab[addr];
    end
  end

  assign cos_mag = r_cos;
  assign sin_mag = r_sin;

endmodule
`default_nettype wire

// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_gen
// Description : 2-stage FFT twiddle generator using octant folding of a small ROM.
//               Option macro: TWIDDLE_ZERO_BYPASS_EN (k=0 returns 0/0).
// Revision    : 1.0
// ============================================================================
module twiddle_gen
  import r22sdf_pkg::*;
#(
  parameter int LOG_N = c_def_log_n,
  parameter int WIDTH = c_def_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tin_en,
  input  logic [LOG_N-1:0] taddr,
  input  logic             tinv,
  output logic             tout_en,
  output logic [WIDTH-1:0] tdata_r,
  output logic [WIDTH-1:0] tdata_i
);

  localparam int c_aw = LOG_N - 2;

  fold_t            w_fold;
  logic             w_unused_j;
  logic [WIDTH-1:0] w_cos;
  logic [WIDTH-1:0] w_sin;
  logic [WIDTH-1:0] w_res_r;
  logic [WIDTH-1:0] w_res_i;

  logic             r_v1;
  logic             r_swap1;
  logic             r_neg_r1;
  logic             r_neg_i1;
  logic             r_v2;
  logic [WIDTH-1:0] r_data_r;
  logic [WIDTH-1:0] r_data_i;
`ifdef TWIDDLE_ZERO_BYPASS_EN
  logic             r_zero1;
`endif

  assign w_fold     = fold(c_max_log_n'(taddr), LOG_N);
  assign w_unused_j = |(w_fold.j >> c_aw);

  twiddle_rom #(
    .LOG_N (LOG_N),
    .WIDTH (WIDTH)
  ) u_rom (
    .clock   (clock),
    .reset   (reset),
    .en      (tin_en),
    .addr    (w_fold.j[c_aw-1:0]),
    .cos_mag (w_cos),
    .sin_mag (w_sin)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v1     <= 1'b0;
      r_swap1  <= 1'b0;
      r_neg_r1 <= 1'b0;
      r_neg_i1 <= 1'b0;
`ifdef TWIDDLE_ZERO_BYPASS_EN
      r_zero1  <= 1'b0;
`endif
    end else begin
      r_v1 <= tin_en;
      if (tin_en) begin
        r_swap1  <= w_fold.swap;
        r_neg_r1 <= w_fold.neg_c;
        // Forward twiddle carries -sin; the conjugate flips that back.
        r_neg_i1 <= ~w_fold.neg_s ^ tinv;
`ifdef TWIDDLE_ZERO_BYPASS_EN
        r_zero1  <= (taddr == '0);
`endif
      end
    end
  end

  // Magnitude 2^(WIDTH-1) is +1.0: saturate when positive, exact when negated.
  function automatic logic [WIDTH-1:0] f_sign(input logic [WIDTH-1:0] mag, input logic neg);
    logic [WIDTH-1:0] res;
    if (neg)               res = -mag;
    else if (mag[WIDTH-1]) res = {1'b0, {(WIDTH-1){1'b1}}};
    else                   res = mag;
    return res;
  endfunction

  always_comb begin
    w_res_r = f_sign(r_swap1 ? w_sin : w_cos, r_neg_r1);
    w_res_i = f_sign(r_swap1 ? w_cos : w_sin, r_neg_i1);
`ifdef TWIDDLE_ZERO_BYPASS_EN
    if (r_zero1) begin
      w_res_r = '0;
      w_res_i = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v2     <= 1'b0;
      r_data_r <= '0;
      r_data_i <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data_r <= w_res_r;
        r_data_i <= w_res_i;
      end
    end
  end

  assign tout_en = r_v2;
  assign tdata_r = r_data_r;
  assign tdata_i = r_data_i;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_gen
// Description : Directed bench for twiddle_gen at LOG_N=6, 4 and 8 (WIDTH=16).
// Revision    : 1.0
// ============================================================================
module tb_twiddle_gen;
  import r22sdf_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        tin_en;
  logic        tinv;
  logic [7:0]  k_drv;
  logic        o_en [3];
  logic [15:0] o_r  [3];
  logic [15:0] o_i  [3];

  int n_total = 0;
  int n_bad   = 0;

  logic        p1_v [3];
  logic        p2_v [3];
  logic [31:0] p1_d [3];
  logic [31:0] p2_d [3];
  logic [31:0] last [3];

  always #5 clock = ~clock;

  twiddle_gen #(.LOG_N(6), .WIDTH(16)) u_dut6 (
    .clock(clock), .reset(reset), .tin_en(tin_en), .taddr(k_drv[5:0]), .tinv(tinv),
    .tout_en(o_en[0]), .tdata_r(o_r[0]), .tdata_i(o_i[0]));
  twiddle_gen #(.LOG_N(4), .WIDTH(16)) u_dut4 (
    .clock(clock), .reset(reset), .tin_en(tin_en), .taddr(k_drv[3:0]), .tinv(tinv),
    .tout_en(o_en[1]), .tdata_r(o_r[1]), .tdata_i(o_i[1]));
  twiddle_gen #(.LOG_N(8), .WIDTH(16)) u_dut8 (
    .clock(clock), .reset(reset), .tin_en(tin_en), .taddr(k_drv[7:0]), .tinv(tinv),
    .tout_en(o_en[2]), .tdata_r(o_r[2]), .tdata_i(o_i[2]));

  function automatic int logn_of(input int d);
    return (d == 0) ? 6 : (d == 1) ? 4 : 8;
  endfunction

  function automatic logic [15:0] q(input real x);
    real s;
    int  v;
    s = x * 32768.0;
    if (s >= 0.0) v = $rtoi(s + 0.5);
    else          v = -$rtoi(-s + 0.5);
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  function automatic logic [31:0] model(input int log_n, input int k, input logic inv);
    real th;
    th = -2.0 * c_pi * k / $itor(1 << log_n);
`ifdef TWIDDLE_ZERO_BYPASS_EN
    if (k == 0) return 32'h0;
`endif
    return {q($cos(th)), q(inv ? -$sin(th) : $sin(th))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      p1_v[d] = 1'b0; p2_v[d] = 1'b0;
      p1_d[d] = '0;   p2_d[d] = '0;   last[d] = '0;
    end
  endtask

  // One clock: drive on the falling edge, then check every DUT just after the rise.
  task automatic step(input logic en, input int k, input logic inv);
    @(negedge clock);
    tin_en = en;
    k_drv  = 8'(k);
    tinv   = inv;
    @(posedge clock);
    for (int d = 0; d < 3; d++) begin
      p2_v[d] = p1_v[d];
      p2_d[d] = p1_d[d];
      p1_v[d] = en;
      if (en) p1_d[d] = model(logn_of(d), k % (1 << logn_of(d)), inv);
      if (p2_v[d]) last[d] = p2_d[d];
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("en_n%0d_k%0d", logn_of(d), k), 32'(o_en[d]), 32'(p2_v[d]));
      chk($sformatf("data_n%0d_k%0d", logn_of(d), k), {o_r[d], o_i[d]}, last[d]);
    end
  endtask

  task automatic req(input string tag, input int k, input logic inv,
                     input logic [15:0] er, input logic [15:0] ei);
    step(1'b1, k, inv);
    step(1'b0, 0, 1'b0);
    chk({tag, "_v"}, 32'(o_en[0]), 32'd1);
    chk(tag, {o_r[0], o_i[0]}, {er, ei});
  endtask

  initial begin
    reset  = 1'b0;
    tin_en = 1'b0;
    tinv   = 1'b0;
    k_drv  = '0;
    clear_model();
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_en_%0d", d), 32'(o_en[d]), 32'd0);
      chk($sformatf("rst_data_%0d", d), {o_r[d], o_i[d]}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    req("k1",     1, 1'b0, 16'h7F62, 16'hF374);
    req("k16",   16, 1'b0, 16'h0000, 16'h8000);
    req("k24",   24, 1'b0, 16'hA57E, 16'hA57E);
    req("k33",   33, 1'b0, 16'h809E, 16'h0C8C);
    req("k8i",    8, 1'b1, 16'h5A82, 16'h5A82);
    req("k45i",  45, 1'b1, 16'hDAD8, 16'h8583);
`ifdef TWIDDLE_ZERO_BYPASS_EN
    req("k0",     0, 1'b0, 16'h0000, 16'h0000);
    req("k0i",    0, 1'b1, 16'h0000, 16'h0000);
`else
    req("k0",     0, 1'b0, 16'h7FFF, 16'h0000);
    req("k0i",    0, 1'b1, 16'h7FFF, 16'h0000);
`endif

    // Full-rate sweep covers every index of all three sizes.
    for (int k = 0; k < 256; k++) step(1'b1, k, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // tinv alternating per request.
    for (int k = 0; k < 64; k++) step(1'b1, k, 1'(k & 1));
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // Gapped stream: results shift by two with data held in the gap.
    step(1'b1, 3, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 7, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // Reset in the middle of a stream.
    for (int k = 10; k < 20; k++) step(1'b1, k, 1'b0);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("arst_en_%0d", d), 32'(o_en[d]), 32'd0);
      chk($sformatf("arst_data_%0d", d), {o_r[d], o_i[d]}, 32'd0);
    end
    tin_en = 1'b0;
    clear_model();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    req("post_rst_k5", 5, 1'b0, 16'h70E3, 16'hC3A9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
